// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input vector of a small combinational unit
// in ascending order, samples its output after a settle time, packs the
// results into a table and compares it against an expected table latched at
// start.
module truth_table_sweeper #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [(1 << N_IN)-1:0]   expected,
    output logic [N_IN-1:0]          vec_out,
    input  logic                     dut_out,
    output logic                     busy,
    output logic                     done,
    output logic [(1 << N_IN)-1:0]   table_out,
    output logic                     pass,
    output logic [N_IN:0]            err_count,
    output logic [N_IN-1:0]          first_fail
);

    localparam int unsigned V  = 1 << N_IN;
    // Counter needs at least one bit even when SETTLE is 1.
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0]   CntLast = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VecLast = N_IN'(V - 1);
    localparam logic [N_IN-1:0] VecOne  = N_IN'(1);
    localparam logic [CW-1:0]   CntOne  = CW'(1);
    localparam logic [N_IN:0]   ErrOne  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [V-1:0]  exp_q;
    logic          miss;

    // Mismatch between the unit's output and the latched expectation for the current vector.
    assign miss = dut_out ^ exp_q[vec_out];

    // Status flags decode directly from the registered state.
    assign busy = (state == StSweep);
    assign done = (state == StDone);

    // Sweep controller: state, vector/settle counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            exp_q      <= '0;
            vec_out    <= '0;
            table_out  <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    vec_out <= '0;
                    // start wins over abort here; abort only matters mid-sweep.
                    if (start) begin
                        state      <= StSweep;
                        exp_q      <= expected;
                        table_out  <= '0;
                        cnt        <= '0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                    end
                end
                StSweep: begin
                    if (abort) begin
                        // Partial capture in table_out is kept for inspection.
                        state   <= StIdle;
                        vec_out <= '0;
                        pass    <= 1'b0;
                    end else if (cnt < CntLast) begin
                        cnt <= cnt + CntOne;
                    end else begin
                        table_out[vec_out] <= dut_out;
                        cnt                <= '0;
                        if (miss) begin
                            err_count <= err_count + ErrOne;
                            if (err_count == '0) begin
                                first_fail <= vec_out;
                            end
                        end
                        if (vec_out == VecLast) begin
                            state <= StDone;
                            // Include the final vector's comparison in the verdict.
                            pass  <= (err_count == '0) && !miss;
                        end else begin
                            vec_out <= vec_out + VecOne;
                        end
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    vec_out <= '0;
                end
                default: begin
                    state   <= StIdle;
                    vec_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: a default 2-input/settle-2
// instance and a 3-input/settle-1 instance, each driving a modelled unit.
module tb_truth_table_sweeper;

    localparam int NA = 2;
    localparam int SA = 2;
    localparam int VA = 4;
    localparam int NB = 3;
    localparam int SB = 1;
    localparam int VB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic          start_a = 1'b0;
    logic          abort_a = 1'b0;
    logic [VA-1:0] exp_a   = '0;
    logic [VA-1:0] unit_a  = '0;
    logic [NA-1:0] vec_a;
    logic          dout_a;
    logic          busy_a, done_a, pass_a;
    logic [VA-1:0] tbl_a;
    logic [NA:0]   err_a;
    logic [NA-1:0] ff_a;

    // Instance B signals
    logic          start_b = 1'b0;
    logic          abort_b = 1'b0;
    logic [VB-1:0] exp_b   = '0;
    logic [VB-1:0] unit_b  = '0;
    logic [NB-1:0] vec_b;
    logic          dout_b;
    logic          busy_b, done_b, pass_b;
    logic [VB-1:0] tbl_b;
    logic [NB:0]   err_b;
    logic [NB-1:0] ff_b;

    // Modelled combinational units: output is a table lookup on the vector.
    assign dout_a = unit_a[vec_a];
    assign dout_b = unit_b[vec_b];

    truth_table_sweeper #(.N_IN(NA), .SETTLE(SA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
        .vec_out(vec_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .table_out(tbl_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
    );

    truth_table_sweeper #(.N_IN(NB), .SETTLE(SB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_b),
        .vec_out(vec_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .table_out(tbl_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: count differing bits and find the lowest one.
    function automatic void model(input logic [7:0] unit, input logic [7:0] expv, input int v,
                                  output logic p, output int errs, output int ff);
        errs = 0;
        ff   = 0;
        for (int k = v - 1; k >= 0; k--) begin
            if (unit[k] !== expv[k]) begin
                errs++;
                ff = k;
            end
        end
        p = (errs == 0);
    endfunction

    task automatic chk_zero_a(input string tag);
        chk({tag, "_vec"},  32'(vec_a),  0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_done"}, 32'(done_a), 0);
        chk({tag, "_tbl"},  32'(tbl_a),  0);
        chk({tag, "_pass"}, 32'(pass_a), 0);
        chk({tag, "_err"},  32'(err_a),  0);
        chk({tag, "_ff"},   32'(ff_a),   0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_vec"},  32'(vec_b),  0);
        chk({tag, "_busy"}, 32'(busy_b), 0);
        chk({tag, "_done"}, 32'(done_b), 0);
        chk({tag, "_tbl"},  32'(tbl_b),  0);
        chk({tag, "_pass"}, 32'(pass_b), 0);
        chk({tag, "_err"},  32'(err_b),  0);
        chk({tag, "_ff"},   32'(ff_b),   0);
    endtask

    // One sweep on instance A. abort_j >= 0 raises abort after accept+abort_j edges.
    task automatic run_a(input logic [3:0] unit, input logic [3:0] expv, input bit hold_start,
                         input bit toggle_exp, input bit both, input int abort_j);
        logic       p;
        int         e, f;
        logic [3:0] mask;
        @(negedge clk);
        unit_a  = unit;
        exp_a   = expv;
        start_a = 1'b1;
        abort_a = both;
        @(negedge clk);
        if (!hold_start) start_a = 1'b0;
        abort_a = 1'b0;
        for (int j = 0; j < VA * SA; j++) begin
            chk("a_busy", 32'(busy_a), 1);
            chk("a_vec",  32'(vec_a),  32'(j / SA));
            chk("a_done", 32'(done_a), 0);
            if (toggle_exp && j == 2) exp_a = ~expv;
            if (j == abort_j) abort_a = 1'b1;
            @(negedge clk);
            if (j == abort_j) begin
                abort_a = 1'b0;
                start_a = 1'b0;
                mask    = 4'((1 << (j / SA)) - 1);
                chk("a_abort_busy", 32'(busy_a), 0);
                chk("a_abort_done", 32'(done_a), 0);
                chk("a_abort_vec",  32'(vec_a),  0);
                chk("a_abort_pass", 32'(pass_a), 0);
                chk("a_abort_tbl",  32'(tbl_a),  32'(unit & mask));
                @(negedge clk);
                chk("a_abort_nodone", 32'(done_a), 0);
                chk("a_abort_idle",   32'(busy_a), 0);
                return;
            end
        end
        model({4'b0, unit}, {4'b0, expv}, VA, p, e, f);
        chk("a_done_hi", 32'(done_a), 1);
        chk("a_done_busy", 32'(busy_a), 0);
        chk("a_tbl",  32'(tbl_a),  32'(unit));
        chk("a_pass", 32'(pass_a), 32'(p));
        chk("a_err",  32'(err_a),  32'(e));
        chk("a_ff",   32'(ff_a),   32'(f));
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        start_a = 1'b0;
        chk("a_post_done", 32'(done_a), 0);
        chk("a_post_busy", 32'(busy_a), 0);
        chk("a_post_vec",  32'(vec_a),  0);
        chk("a_hold_tbl",  32'(tbl_a),  32'(unit));
        chk("a_hold_pass", 32'(pass_a), 32'(p));
        chk("a_hold_err",  32'(err_a),  32'(e));
        chk("a_hold_ff",   32'(ff_a),   32'(f));
        @(negedge clk);
        chk("a_no_reaccept", 32'(busy_a), 0);
    endtask

    task automatic run_b(input logic [7:0] unit, input logic [7:0] expv);
        logic p;
        int   e, f;
        @(negedge clk);
        unit_b  = unit;
        exp_b   = expv;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int j = 0; j < VB * SB; j++) begin
            chk("b_busy", 32'(busy_b), 1);
            chk("b_vec",  32'(vec_b),  32'(j / SB));
            chk("b_done", 32'(done_b), 0);
            @(negedge clk);
        end
        model(unit, expv, VB, p, e, f);
        chk("b_done_hi", 32'(done_b), 1);
        chk("b_tbl",  32'(tbl_b),  32'(unit));
        chk("b_pass", 32'(pass_b), 32'(p));
        chk("b_err",  32'(err_b),  32'(e));
        chk("b_ff",   32'(ff_b),   32'(f));
        @(negedge clk);
        chk("b_post_done", 32'(done_b), 0);
        chk("b_post_vec",  32'(vec_b),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_a("rst_a");
        chk_zero_b("rst_b");
        rst_n = 1'b1;
        @(negedge clk);
        abort_a = 1'b1;  // abort in IDLE is ignored
        @(negedge clk);
        abort_a = 1'b0;
        chk_zero_a("idle_a");

        run_a(4'b1000, 4'b1000, 0, 0, 0, -1);  // AND, pass
        run_a(4'b0110, 4'b1000, 0, 0, 0, -1);  // XOR, 3 errors, first at 1
        run_a(4'b1000, 4'b1000, 0, 0, 0, 5);   // abort in 2nd cycle of vector 2
        run_a(4'b1000, 4'b1000, 0, 0, 0, -1);  // clean sweep after abort
        run_a(4'b1000, 4'b1000, 1, 1, 0, -1);  // start held, expected toggled
        run_a(4'(($urandom)), 4'(($urandom)), 0, 0, 1, -1);  // start+abort together
        run_a(4'b1011, 4'b1000, 0, 0, 0, 7);   // abort on the last sampling edge

        // Asynchronous reset mid-sweep
        @(negedge clk);
        unit_a  = 4'b1111;
        exp_a   = 4'b1111;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_a("arst_a");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("arst_nodone", 32'(done_a), 0);
        end
        chk("arst_idle", 32'(busy_a), 0);

        run_b(8'hFE, 8'hFE);  // OR-of-3, pass
        run_b(8'h80, 8'hFE);  // AND-of-3 against OR table

        for (int i = 0; i < 6; i++) begin
            run_a(4'($urandom), 4'($urandom), 0, 0, 0,
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1);
            run_b(8'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
